rlc_game_system_leds_pio: RTL and testbench

RLC_GAME_SYSTEM_LEDS_PIO -- requirements
Module: rlc_game_system_leds_pio

---
 rtl/rlc_game_system_leds_pio_if.sv | 25 ++
 rtl/rlc_game_system_leds_pio.sv | 98 +++++++++
 tb/tb_rlc_game_system_leds_pio.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rlc_game_system_leds_pio_if.sv
// Avalon-MM slave bus bundle for the LED PIO block.
// The master side drives address and write controls; the slave returns registered read data.
interface rlc_game_system_leds_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/rlc_game_system_leds_pio.sv
// LED PIO with set/clear write ports and a programmable blink timer.
// Bits selected by blink_mask are forced low while the blink phase is high.
module rlc_game_system_leds_pio #(
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic                          clk,
    input  logic                          reset_n,
    rlc_game_system_leds_pio_if.slave     bus,
    output logic [7:0]                    out_port
);

    logic [7:0]  r_data;
    logic [7:0]  r_blink_mask;
    logic [23:0] r_blink_period;
    logic [23:0] r_counter;
    logic        r_phase;
    logic [31:0] r_readdata;

    logic        w_write;
    logic        w_period_write;
    logic        w_unused_bits;

    assign w_write        = bus.chipselect & ~bus.write_n;
    assign w_period_write = w_write && (bus.address == 3'd2);

    // Upper write-data bits carry no meaning for any register.
    assign w_unused_bits  = &{1'b0, bus.writedata[31:24]};

    // Data register: direct load, bitwise set and bitwise clear ports.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= RESET_VALUE;
        end else if (w_write) begin
            case (bus.address)
                3'd0:    r_data <= bus.writedata[7:0];
                3'd4:    r_data <= r_data | bus.writedata[7:0];
                3'd5:    r_data <= r_data & ~bus.writedata[7:0];
                default: r_data <= r_data;
            endcase
        end
    end

    // Blink mask register; changing it leaves the timer untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_mask <= 8'h00;
        end else if (w_write && (bus.address == 3'd1)) begin
            r_blink_mask <= bus.writedata[7:0];
        end
    end

    // Blink period register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_period <= 24'd0;
        end else if (w_period_write) begin
            r_blink_period <= bus.writedata[23:0];
        end
    end

    // Blink timer: a period write restarts it and wins over a coincident terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_counter <= 24'd0;
            r_phase   <= 1'b0;
        end else if (w_period_write) begin
            r_counter <= 24'd0;
            r_phase   <= 1'b0;
        end else if (r_blink_period == 24'd0) begin
            r_counter <= 24'd0;
            r_phase   <= 1'b0;
        end else if (r_counter >= r_blink_period) begin
            r_counter <= 24'd0;
            r_phase   <= ~r_phase;
        end else begin
            r_counter <= r_counter + 24'd1;
        end
    end

    // Read data is captured every clock from the presented address; no strobe needed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 32'd0;
        end else begin
            case (bus.address)
                3'd0:    r_readdata <= {24'd0, r_data};
                3'd1:    r_readdata <= {24'd0, r_blink_mask};
                3'd2:    r_readdata <= {8'd0, r_blink_period};
                3'd3:    r_readdata <= {31'd0, r_phase};
                default: r_readdata <= 32'd0;
            endcase
        end
    end

    assign bus.readdata = r_readdata;
    assign out_port     = r_data & ~(r_blink_mask & {8{r_phase}});

endmodule

// File: tb/tb_rlc_game_system_leds_pio.sv
// Self-checking bench for the LED PIO: cycle-level reference model plus directed literal checks.
module tb_rlc_game_system_leds_pio;

    logic       clk;
    logic       reset_n;
    logic [7:0] outPort;

    rlc_game_system_leds_pio_if busIf ();

    rlc_game_system_leds_pio #(
        .RESET_VALUE (8'hA5)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (busIf),
        .out_port (outPort)
    );

    int errorCount = 0;
    int checkCount = 0;

    // Reference model state: the blink phase is derived from edges elapsed since the timer restarted.
    logic [7:0]  mData;
    logic [7:0]  mMask;
    int          mPeriod;
    int          mCycle;
    int          mStart;
    logic [31:0] mReadData;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic modelPhase();
        if (mPeriod == 0) return 1'b0;
        return (((mCycle - mStart) / (mPeriod + 1)) % 2) == 1;
    endfunction

    function automatic logic [7:0] modelOut();
        return mData & ~(mMask & {8{modelPhase()}});
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %08h, expected %08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model update on every rising edge, mirroring the register map at the behavioural level.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mData     = 8'hA5;
            mMask     = 8'h00;
            mPeriod   = 0;
            mCycle    = 0;
            mStart    = 0;
            mReadData = 32'd0;
        end else begin
            case (busIf.address)
                3'd0:    mReadData = {24'd0, mData};
                3'd1:    mReadData = {24'd0, mMask};
                3'd2:    mReadData = mPeriod;
                3'd3:    mReadData = {31'd0, modelPhase()};
                default: mReadData = 32'd0;
            endcase
            mCycle++;
            if (busIf.chipselect && !busIf.write_n) begin
                case (busIf.address)
                    3'd0: mData = busIf.writedata[7:0];
                    3'd1: mMask = busIf.writedata[7:0];
                    3'd2: begin
                        mPeriod = int'(busIf.writedata[23:0]);
                        mStart  = mCycle;
                    end
                    3'd4: mData = mData | busIf.writedata[7:0];
                    3'd5: mData = mData & ~busIf.writedata[7:0];
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            checkOutput("model out_port", {24'd0, outPort}, {24'd0, modelOut()});
            checkOutput("model readdata", busIf.readdata, mReadData);
        end
    end

    // One write cycle; returns on the falling edge right after the write edge.
    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] wdata);
        busIf.address    = addr;
        busIf.writedata  = wdata;
        busIf.chipselect = 1'b1;
        busIf.write_n    = 1'b0;
        @(negedge clk);
        busIf.chipselect = 1'b0;
        busIf.write_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        reset_n          = 1'b0;
        busIf.address    = 3'd0;
        busIf.chipselect = 1'b0;
        busIf.write_n    = 1'b1;
        busIf.writedata  = 32'd0;

        repeat (3) @(negedge clk);
        checkOutput("reset out_port", {24'd0, outPort}, 32'h0000_00A5);
        checkOutput("reset readdata", busIf.readdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("read reset value", busIf.readdata, 32'h0000_00A5);

        applyStimulus(3'd0, 32'hFFFF_FF0F);
        checkOutput("data load", {24'd0, outPort}, 32'h0F);
        applyStimulus(3'd4, 32'h0000_00F0);
        checkOutput("outset", {24'd0, outPort}, 32'hFF);
        applyStimulus(3'd5, 32'h0000_003C);
        checkOutput("outclear", {24'd0, outPort}, 32'hC3);
        busIf.address = 3'd4;
        @(negedge clk);
        checkOutput("read addr4", busIf.readdata, 32'd0);

        applyStimulus(3'd0, 32'h0000_00FF);
        applyStimulus(3'd1, 32'h0000_0081);
        applyStimulus(3'd2, 32'h0000_0003);
        busIf.address = 3'd3;
        checkOutput("blink e0", {24'd0, outPort}, 32'hFF);
        repeat (3) @(negedge clk);
        checkOutput("blink e3", {24'd0, outPort}, 32'hFF);
        @(negedge clk);
        checkOutput("blink e4", {24'd0, outPort}, 32'h7E);
        repeat (4) @(negedge clk);
        checkOutput("blink e8", {24'd0, outPort}, 32'hFF);
        repeat (4) @(negedge clk);
        checkOutput("blink e12", {24'd0, outPort}, 32'h7E);
        @(negedge clk);
        checkOutput("status phase", busIf.readdata, 32'd1);

        applyStimulus(3'd2, 32'd0);
        checkOutput("stop blink", {24'd0, outPort}, 32'hFF);
        busIf.address = 3'd3;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (outPort !== 8'hFF) begin
                checkOutput("stopped hold", {24'd0, outPort}, 32'hFF);
                break;
            end
        end
        checkOutput("stopped status", busIf.readdata, 32'd0);

        applyStimulus(3'd2, 32'd3);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (outPort == 8'h7E) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("phase rise wait", {31'd0, seen}, 32'd1);
        applyStimulus(3'd2, 32'd3);
        repeat (3) @(negedge clk);
        applyStimulus(3'd2, 32'd2);
        checkOutput("tc write wins", {24'd0, outPort}, 32'hFF);
        repeat (2) @(negedge clk);
        checkOutput("tc restart e2", {24'd0, outPort}, 32'hFF);
        @(negedge clk);
        checkOutput("tc restart e3", {24'd0, outPort}, 32'h7E);

        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset out", {24'd0, outPort}, 32'hA5);
        checkOutput("async reset rd", busIf.readdata, 32'd0);
        busIf.address    = 3'd0;
        busIf.writedata  = 32'h11;
        busIf.chipselect = 1'b1;
        busIf.write_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("write in reset", {24'd0, outPort}, 32'hA5);
        @(negedge clk);
        busIf.chipselect = 1'b0;
        busIf.write_n    = 1'b1;
        reset_n          = 1'b1;

        applyStimulus(3'd0, 32'h55);
        checkOutput("post reset write", {24'd0, outPort}, 32'h55);
        applyStimulus(3'd3, 32'hFF);
        applyStimulus(3'd6, 32'hFF);
        applyStimulus(3'd7, 32'h00);
        checkOutput("ignored writes", {24'd0, outPort}, 32'h55);
        applyStimulus(3'd1, 32'hABCD_EF0F);
        applyStimulus(3'd2, 32'h12AB_CDEF);
        for (int a = 0; a < 8; a++) begin
            busIf.address = a[2:0];
            @(negedge clk);
        end
        busIf.address = 3'd2;
        @(negedge clk);
        checkOutput("read period", busIf.readdata, 32'h00AB_CDEF);
        busIf.address = 3'd1;
        @(negedge clk);
        checkOutput("read mask", busIf.readdata, 32'h0000_000F);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
